// File: rtl/spart_driver_if.sv
// Bus control signals between the SPART driver (master) and the SPART (slave).
// The shared data bus stays a plain inout port on the driver.
interface spart_driver_if;
    logic       iocs_n;
    logic       iorw_n;
    logic [1:0] ioaddr;
    logic       tx_q_full;
    logic       rx_q_empty;

    modport master (
        output iocs_n,
        output iorw_n,
        output ioaddr,
        input  tx_q_full,
        input  rx_q_empty
    );

    modport slave (
        input  iocs_n,
        input  iorw_n,
        input  ioaddr,
        output tx_q_full,
        output rx_q_empty
    );
endinterface

// File: rtl/spart_driver.sv
// SPART driver: programs the baud divisor, polls status and echoes every
// received byte back to the transmitter through a 4-entry FIFO.
module spart_driver (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      br_cfg,
    spart_driver_if.master  bus,
    inout  wire  [7:0]      databus,
    output logic            cfg_done,
    output logic [7:0]      last_rx,
    output logic [2:0]      echo_cnt
);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_CFG_LO,
        ST_CFG_HI,
        ST_STAT,
        ST_RD,
        ST_WR
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [1:0]  r_sync1;
    logic [1:0]  r_sync2;
    logic [12:0] r_div;
    logic        r_pend;
    logic        r_cfg_done;
    logic [7:0]  r_last_rx;
    logic [7:0]  r_mem [4];
    logic [1:0]  r_wptr;
    logic [1:0]  r_rptr;
    logic [2:0]  r_cnt;

    logic        w_cs_n;
    logic        w_rw_n;
    logic [1:0]  w_addr;
    logic        w_drive;
    logic [7:0]  w_wdata;
    logic [3:0]  w_tx_free;
    logic [3:0]  w_rx_cnt;
    logic        w_cfg_change;
    logic        w_push;
    logic        w_pop;
    logic [7:0]  w_head;

    // Queue flags are informational only; the status register is authoritative.
    logic        w_unused_flags;
    assign w_unused_flags = bus.tx_q_full ^ bus.rx_q_empty;

    function automatic logic [12:0] div_for(input logic [1:0] sel);
        case (sel)
            2'b00:   return 13'd650;
            2'b01:   return 13'd325;
            2'b10:   return 13'd162;
            default: return 13'd80;
        endcase
    endfunction

    assign w_tx_free    = databus[7:4];
    assign w_rx_cnt     = databus[3:0];
    assign w_cfg_change = (r_sync1 != r_sync2);
    assign w_push       = (r_state == ST_RD) && (r_cnt != 3'd4);
    assign w_pop        = (r_state == ST_WR) && (r_cnt != 3'd0);
    assign w_head       = r_mem[r_rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    // Bus strobes decode from r_state only; the STAT decision looks at the live bus.
    always_comb begin
        w_next  = r_state;
        w_cs_n  = 1'b1;
        w_rw_n  = 1'b1;
        w_addr  = 2'b01;
        w_drive = 1'b0;
        w_wdata = 8'h00;
        case (r_state)
            ST_INIT: begin
                w_next = ST_CFG_LO;
            end
            ST_CFG_LO: begin
                w_cs_n  = 1'b0;
                w_rw_n  = 1'b0;
                w_addr  = 2'b10;
                w_drive = 1'b1;
                w_wdata = r_div[7:0];
                w_next  = ST_CFG_HI;
            end
            ST_CFG_HI: begin
                w_cs_n  = 1'b0;
                w_rw_n  = 1'b0;
                w_addr  = 2'b11;
                w_drive = 1'b1;
                w_wdata = {3'b000, r_div[12:8]};
                w_next  = ST_STAT;
            end
            ST_STAT: begin
                w_cs_n = 1'b0;
                w_addr = 2'b01;
                if (r_pend) begin
                    w_next = ST_CFG_LO;
                end else if ((r_cnt != 3'd0) && (w_tx_free != 4'd0)) begin
                    w_next = ST_WR;
                end else if ((w_rx_cnt != 4'd0) && (r_cnt < 3'd4)) begin
                    w_next = ST_RD;
                end else begin
                    w_next = ST_STAT;
                end
            end
            ST_RD: begin
                w_cs_n = 1'b0;
                w_addr = 2'b00;
                w_next = ST_STAT;
            end
            ST_WR: begin
                w_cs_n  = 1'b0;
                w_rw_n  = 1'b0;
                w_addr  = 2'b00;
                w_drive = 1'b1;
                w_wdata = w_head;
                w_next  = ST_STAT;
            end
            default: begin
                w_next = ST_INIT;
            end
        endcase
    end

    // A change seen at the same edge as CFG_LO entry keeps pending set, since
    // the divisor latched on that edge is still the old one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= 2'b00;
            r_sync2    <= 2'b00;
            r_div      <= 13'd650;
            r_pend     <= 1'b0;
            r_cfg_done <= 1'b0;
        end else begin
            r_sync1 <= br_cfg;
            r_sync2 <= r_sync1;
            if (w_next == ST_CFG_LO && r_state != ST_CFG_LO) begin
                r_div <= div_for(r_sync2);
            end
            if (w_cfg_change) begin
                r_pend <= 1'b1;
            end else if (w_next == ST_CFG_LO) begin
                r_pend <= 1'b0;
            end
            if (w_cfg_change) begin
                r_cfg_done <= 1'b0;
            end else if (r_state == ST_CFG_HI && !r_pend) begin
                r_cfg_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_rx <= 8'h00;
            r_wptr    <= 2'd0;
            r_rptr    <= 2'd0;
            r_cnt     <= 3'd0;
        end else begin
            if (r_state == ST_RD) begin
                r_last_rx <= databus;
            end
            if (w_push) begin
                r_wptr <= r_wptr + 2'd1;
                r_cnt  <= r_cnt + 3'd1;
            end else if (w_pop) begin
                r_rptr <= r_rptr + 2'd1;
                r_cnt  <= r_cnt - 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= databus;
        end
    end

    assign bus.iocs_n = w_cs_n;
    assign bus.iorw_n = w_rw_n;
    assign bus.ioaddr = w_addr;
    assign databus    = w_drive ? w_wdata : 8'hzz;
    assign cfg_done   = r_cfg_done;
    assign last_rx    = r_last_rx;
    assign echo_cnt   = r_cnt;

endmodule

// File: tb/tb_spart_driver.sv
// Cycle-accurate directed bench for spart_driver with a tiny SPART bus model:
// it answers reads with the vector's byte and holds 0xA5 on the idle bus.
module tb_spart_driver;

    localparam int K_IDLE = 0;
    localparam int K_WLO  = 1;
    localparam int K_WHI  = 2;
    localparam int K_STAT = 3;
    localparam int K_RD   = 4;
    localparam int K_WR   = 5;
    localparam int NVEC   = 43;

    typedef struct {
        logic [1:0] br;
        logic [7:0] din;
        int         kind;
        logic [7:0] wd;
        logic       done;
        logic [7:0] last;
        logic [2:0] cnt;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] br_cfg;
    logic [7:0] din;
    wire  [7:0] databus;
    logic       cfg_done;
    logic [7:0] last_rx;
    logic [2:0] echo_cnt;

    int n_checks;
    int n_fail;

    vec_t tv [NVEC];
    vec_t post [4];

    spart_driver_if bus_if ();

    assign bus_if.tx_q_full  = 1'b0;
    assign bus_if.rx_q_empty = 1'b1;
    assign databus = (!bus_if.iocs_n && !bus_if.iorw_n) ? 8'hzz :
                     (bus_if.iocs_n ? 8'hA5 : din);

    spart_driver dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .br_cfg   (br_cfg),
        .bus      (bus_if),
        .databus  (databus),
        .cfg_done (cfg_done),
        .last_rx  (last_rx),
        .echo_cnt (echo_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [1:0] br, input logic [7:0] d, input int kind,
                                input logic [7:0] wd, input logic done,
                                input logic [7:0] last, input logic [2:0] cnt);
        vec_t v;
        v.br   = br;
        v.din  = d;
        v.kind = kind;
        v.wd   = wd;
        v.done = done;
        v.last = last;
        v.cnt  = cnt;
        return v;
    endfunction

    task automatic chk(input string tag, input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s actual=%02h required=%02h", tag, name, act, exp);
        end
    endtask

    task automatic apply_vec(input vec_t v);
        br_cfg = v.br;
        din    = v.din;
    endtask

    task automatic check_vec(input vec_t v, input string tag);
        logic       e_cs;
        logic       e_rw;
        logic [1:0] e_addr;
        logic [7:0] e_db;
        e_cs = 1'b0; e_rw = 1'b1; e_addr = 2'b01; e_db = v.din;
        case (v.kind)
            K_IDLE: begin e_cs = 1'b1; e_rw = 1'b1; e_addr = 2'b01; e_db = 8'hA5; end
            K_WLO:  begin e_rw = 1'b0; e_addr = 2'b10; e_db = v.wd; end
            K_WHI:  begin e_rw = 1'b0; e_addr = 2'b11; e_db = v.wd; end
            K_STAT: begin e_rw = 1'b1; e_addr = 2'b01; e_db = v.din; end
            K_RD:   begin e_rw = 1'b1; e_addr = 2'b00; e_db = v.din; end
            default: begin e_rw = 1'b0; e_addr = 2'b00; e_db = v.wd; end
        endcase
        chk(tag, "iocs_n",   {7'd0, bus_if.iocs_n}, {7'd0, e_cs});
        chk(tag, "iorw_n",   {7'd0, bus_if.iorw_n}, {7'd0, e_rw});
        chk(tag, "ioaddr",   {6'd0, bus_if.ioaddr}, {6'd0, e_addr});
        chk(tag, "databus",  databus, e_db);
        chk(tag, "cfg_done", {7'd0, cfg_done}, {7'd0, v.done});
        chk(tag, "last_rx",  last_rx, v.last);
        chk(tag, "echo_cnt", {5'd0, echo_cnt}, {5'd0, v.cnt});
        $display("tx %s kind=%0d iocs_n=%0b ioaddr=%0d databus=%02h cfg_done=%0b last_rx=%02h echo_cnt=%0d",
                 tag, v.kind, bus_if.iocs_n, bus_if.ioaddr, databus, cfg_done, last_rx, echo_cnt);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        br_cfg   = 2'b00;
        din      = 8'h00;

        // Startup config, one echo round trip, fill to 4, drain in order, two reconfigs
        tv[0]  = mk(2'b00, 8'h00, K_IDLE, 8'h00, 1'b0, 8'h00, 3'd0);
        tv[1]  = mk(2'b00, 8'h00, K_WLO,  8'h8A, 1'b0, 8'h00, 3'd0);
        tv[2]  = mk(2'b00, 8'h00, K_WHI,  8'h02, 1'b0, 8'h00, 3'd0);
        tv[3]  = mk(2'b00, 8'h81, K_STAT, 8'h00, 1'b1, 8'h00, 3'd0);
        tv[4]  = mk(2'b00, 8'h5A, K_RD,   8'h00, 1'b1, 8'h00, 3'd0);
        tv[5]  = mk(2'b00, 8'h81, K_STAT, 8'h00, 1'b1, 8'h5A, 3'd1);
        tv[6]  = mk(2'b00, 8'h00, K_WR,   8'h5A, 1'b1, 8'h5A, 3'd1);
        tv[7]  = mk(2'b00, 8'h00, K_STAT, 8'h00, 1'b1, 8'h5A, 3'd0);
        tv[8]  = mk(2'b00, 8'h00, K_STAT, 8'h00, 1'b1, 8'h5A, 3'd0);
        tv[9]  = mk(2'b00, 8'h06, K_STAT, 8'h00, 1'b1, 8'h5A, 3'd0);
        tv[10] = mk(2'b00, 8'h11, K_RD,   8'h00, 1'b1, 8'h5A, 3'd0);
        tv[11] = mk(2'b00, 8'h06, K_STAT, 8'h00, 1'b1, 8'h11, 3'd1);
        tv[12] = mk(2'b00, 8'h22, K_RD,   8'h00, 1'b1, 8'h11, 3'd1);
        tv[13] = mk(2'b00, 8'h06, K_STAT, 8'h00, 1'b1, 8'h22, 3'd2);
        tv[14] = mk(2'b00, 8'h33, K_RD,   8'h00, 1'b1, 8'h22, 3'd2);
        tv[15] = mk(2'b00, 8'h06, K_STAT, 8'h00, 1'b1, 8'h33, 3'd3);
        tv[16] = mk(2'b00, 8'h44, K_RD,   8'h00, 1'b1, 8'h33, 3'd3);
        tv[17] = mk(2'b00, 8'h06, K_STAT, 8'h00, 1'b1, 8'h44, 3'd4);
        tv[18] = mk(2'b00, 8'h06, K_STAT, 8'h00, 1'b1, 8'h44, 3'd4);
        tv[19] = mk(2'b00, 8'h86, K_STAT, 8'h00, 1'b1, 8'h44, 3'd4);
        tv[20] = mk(2'b00, 8'h00, K_WR,   8'h11, 1'b1, 8'h44, 3'd4);
        tv[21] = mk(2'b00, 8'h86, K_STAT, 8'h00, 1'b1, 8'h44, 3'd3);
        tv[22] = mk(2'b00, 8'h00, K_WR,   8'h22, 1'b1, 8'h44, 3'd3);
        tv[23] = mk(2'b00, 8'h86, K_STAT, 8'h00, 1'b1, 8'h44, 3'd2);
        tv[24] = mk(2'b00, 8'h00, K_WR,   8'h33, 1'b1, 8'h44, 3'd2);
        tv[25] = mk(2'b00, 8'h86, K_STAT, 8'h00, 1'b1, 8'h44, 3'd1);
        tv[26] = mk(2'b00, 8'h00, K_WR,   8'h44, 1'b1, 8'h44, 3'd1);
        tv[27] = mk(2'b00, 8'h80, K_STAT, 8'h00, 1'b1, 8'h44, 3'd0);
        tv[28] = mk(2'b00, 8'h00, K_STAT, 8'h00, 1'b1, 8'h44, 3'd0);
        tv[29] = mk(2'b01, 8'h00, K_STAT, 8'h00, 1'b1, 8'h44, 3'd0);
        tv[30] = mk(2'b01, 8'h00, K_STAT, 8'h00, 1'b1, 8'h44, 3'd0);
        tv[31] = mk(2'b01, 8'h00, K_STAT, 8'h00, 1'b0, 8'h44, 3'd0);
        tv[32] = mk(2'b01, 8'h00, K_WLO,  8'h45, 1'b0, 8'h44, 3'd0);
        tv[33] = mk(2'b01, 8'h00, K_WHI,  8'h01, 1'b0, 8'h44, 3'd0);
        tv[34] = mk(2'b01, 8'h01, K_STAT, 8'h00, 1'b1, 8'h44, 3'd0);
        tv[35] = mk(2'b11, 8'h77, K_RD,   8'h00, 1'b1, 8'h44, 3'd0);
        tv[36] = mk(2'b11, 8'h00, K_STAT, 8'h00, 1'b1, 8'h77, 3'd1);
        tv[37] = mk(2'b11, 8'h00, K_STAT, 8'h00, 1'b0, 8'h77, 3'd1);
        tv[38] = mk(2'b11, 8'h00, K_WLO,  8'h50, 1'b0, 8'h77, 3'd1);
        tv[39] = mk(2'b11, 8'h00, K_WHI,  8'h00, 1'b0, 8'h77, 3'd1);
        tv[40] = mk(2'b11, 8'h10, K_STAT, 8'h00, 1'b1, 8'h77, 3'd1);
        tv[41] = mk(2'b11, 8'h00, K_WR,   8'h77, 1'b1, 8'h77, 3'd1);
        tv[42] = mk(2'b11, 8'h00, K_STAT, 8'h00, 1'b1, 8'h77, 3'd0);

        post[0] = mk(2'b00, 8'h00, K_IDLE, 8'h00, 1'b0, 8'h00, 3'd0);
        post[1] = mk(2'b00, 8'h00, K_WLO,  8'h8A, 1'b0, 8'h00, 3'd0);
        post[2] = mk(2'b00, 8'h00, K_WHI,  8'h02, 1'b0, 8'h00, 3'd0);
        post[3] = mk(2'b00, 8'h00, K_STAT, 8'h00, 1'b1, 8'h00, 3'd0);

        repeat (3) @(negedge clk);
        #1;
        check_vec(mk(2'b00, 8'h00, K_IDLE, 8'h00, 1'b0, 8'h00, 3'd0), "reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            apply_vec(tv[i]);
            #1;
            check_vec(tv[i], $sformatf("v%0d", i));
            @(negedge clk);
        end

        // Buffer one byte, start its WR, then pulse reset in the middle of it
        apply_vec(mk(2'b11, 8'h01, K_STAT, 8'h00, 1'b1, 8'h77, 3'd0));
        #1;
        check_vec(mk(2'b11, 8'h01, K_STAT, 8'h00, 1'b1, 8'h77, 3'd0), "h0");
        @(negedge clk);
        apply_vec(mk(2'b11, 8'h99, K_RD, 8'h00, 1'b1, 8'h77, 3'd0));
        #1;
        check_vec(mk(2'b11, 8'h99, K_RD, 8'h00, 1'b1, 8'h77, 3'd0), "h1");
        @(negedge clk);
        apply_vec(mk(2'b11, 8'h10, K_STAT, 8'h00, 1'b1, 8'h99, 3'd1));
        #1;
        check_vec(mk(2'b11, 8'h10, K_STAT, 8'h00, 1'b1, 8'h99, 3'd1), "h2");
        @(negedge clk);
        apply_vec(mk(2'b11, 8'h00, K_WR, 8'h99, 1'b1, 8'h99, 3'd1));
        #1;
        check_vec(mk(2'b11, 8'h00, K_WR, 8'h99, 1'b1, 8'h99, 3'd1), "h3");
        #1;
        rst_n  = 1'b0;
        br_cfg = 2'b00;
        #1;
        check_vec(mk(2'b00, 8'h00, K_IDLE, 8'h00, 1'b0, 8'h00, 3'd0), "rst_mid");
        @(negedge clk);
        #1;
        check_vec(mk(2'b00, 8'h00, K_IDLE, 8'h00, 1'b0, 8'h00, 3'd0), "rst_hold");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            apply_vec(post[i]);
            #1;
            check_vec(post[i], $sformatf("p%0d", i));
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
